// File: rtl/seq_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_counter_pkg
// Brief    : Shared state codes and successor functions for the 3-bit
//            reflected Gray sequence counter.
// Revision : 1.0 - initial release
// ============================================================================
package seq_counter_pkg;

  localparam int c_CODE_W = 3;

  // Each state's encoding is its Gray code, so the state register is the
  // output code and no decode is needed on countreg.
  typedef enum logic [c_CODE_W-1:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b011,
    S3 = 3'b010,
    S4 = 3'b110,
    S5 = 3'b111,
    S6 = 3'b101,
    S7 = 3'b100
  } state_t;

  // Forward successor: S0->S1->...->S7->S0.
  function automatic state_t fwd_next(input state_t cur);
    state_t nxt;
    nxt = S0;
    case (cur)
      S0:      nxt = S1;
      S1:      nxt = S2;
      S2:      nxt = S3;
      S3:      nxt = S4;
      S4:      nxt = S5;
      S5:      nxt = S6;
      S6:      nxt = S7;
      S7:      nxt = S0;
      default: nxt = S0;
    endcase
    return nxt;
  endfunction

  // Reverse successor: S0->S7->...->S1->S0.
  function automatic state_t rev_next(input state_t cur);
    state_t nxt;
    nxt = S0;
    case (cur)
      S0:      nxt = S7;
      S7:      nxt = S6;
      S6:      nxt = S5;
      S5:      nxt = S4;
      S4:      nxt = S3;
      S3:      nxt = S2;
      S2:      nxt = S1;
      S1:      nxt = S0;
      default: nxt = S0;
    endcase
    return nxt;
  endfunction

endpackage : seq_counter_pkg
`default_nettype wire

// File: rtl/seq_counter_next.sv
`default_nettype none
// ============================================================================
// Module   : seq_counter_next
// Brief    : Combinational next-state logic for the Gray sequence counter.
//            Direction is fixed at elaboration by REVERSE.
// Revision : 1.0 - initial release
// ============================================================================
module seq_counter_next
  import seq_counter_pkg::*;
#(
  parameter bit REVERSE = 1'b0
) (
  input  state_t i_state,
  output state_t o_next
);

  // Only one direction's table is ever built.
  generate
    if (REVERSE) begin : g_rev
      // Backward traversal of the sequence.
      always_comb begin
        o_next = rev_next(i_state);
      end
    end else begin : g_fwd
      // Forward traversal of the sequence.
      always_comb begin
        o_next = fwd_next(i_state);
      end
    end
  endgenerate

endmodule : seq_counter_next
`default_nettype wire

// File: rtl/seq_counter.sv
`default_nettype none
// ============================================================================
// Module   : seq_counter
// Brief    : 8-state FSM stepping a 3-bit reflected Gray code once per clock,
//            forward or backward, with a configurable reset code.
// Revision : 1.0 - initial release
// ============================================================================
module seq_counter
  import seq_counter_pkg::*;
#(
  parameter bit                REVERSE     = 1'b0,
  parameter logic [c_CODE_W-1:0] RESET_STATE = 3'd0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [c_CODE_W-1:0] countreg
);

  // Every 3-bit value is a valid state, so any RESET_STATE maps to one.
  localparam state_t c_RESET = state_t'(RESET_STATE);

  state_t r_state;
  state_t w_next;

  seq_counter_next #(
    .REVERSE (REVERSE)
  ) u_next (
    .i_state (r_state),
    .o_next  (w_next)
  );

  // State register: reset code has priority over advancing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_RESET;
    end else begin
      r_state <= w_next;
    end
  end

  assign countreg = r_state;

endmodule : seq_counter
`default_nettype wire

// File: tb/tb_seq_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_counter
// Brief    : Bench for seq_counter: forward, reverse and non-zero reset
//            instances checked against an index-based Gray model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_counter;

  logic       clk;
  logic [2:0] rst_v;
  logic [2:0] q0, q1, q2;

  int total;
  int bad;

  // Model state per instance: position in the sequence, validity, and
  // whether the last edge was a plain advance.
  int idx  [3];
  bit mval [3];
  bit adv  [3];
  logic [2:0] prev [3];

  localparam bit       c_REV [3] = '{1'b0, 1'b1, 1'b0};
  localparam logic [2:0] c_RS [3] = '{3'd0, 3'd0, 3'd6};

  seq_counter u_fwd (
    .clk      (clk),
    .rst      (rst_v[0]),
    .countreg (q0)
  );

  seq_counter #(
    .REVERSE (1'b1)
  ) u_rev (
    .clk      (clk),
    .rst      (rst_v[1]),
    .countreg (q1)
  );

  seq_counter #(
    .RESET_STATE (3'd6)
  ) u_rs6 (
    .clk      (clk),
    .rst      (rst_v[2]),
    .countreg (q2)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Gray code of sequence position i.
  function automatic logic [2:0] gray(input int i);
    logic [2:0] b;
    b = 3'(i);
    return b ^ (b >> 1);
  endfunction

  // Sequence position holding a given code.
  function automatic int pos_of(input logic [2:0] code);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (gray(i) == code) p = i;
    return p;
  endfunction

  function automatic logic [2:0] qsel(input int n);
    logic [2:0] v;
    case (n)
      0:       v = q0;
      1:       v = q1;
      default: v = q2;
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge.
  always @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (rst_v[n]) begin
        idx[n]  = pos_of(c_RS[n]);
        mval[n] = 1'b1;
        adv[n]  = 1'b0;
      end else if (mval[n]) begin
        idx[n]  = c_REV[n] ? (idx[n] + 7) % 8 : (idx[n] + 1) % 8;
        adv[n]  = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model plus the one-bit-change rule.
  always @(negedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (mval[n]) begin
        chk($sformatf("model_q%0d", n), qsel(n), gray(idx[n]));
        if (adv[n]) begin
          total++;
          if ($countones(prev[n] ^ qsel(n)) != 1) begin
            bad++;
            $display("FAIL onebit_q%0d: prev %b now %b at %0t", n, prev[n], qsel(n), $time);
          end
        end
        prev[n] = qsel(n);
      end
    end
  end

  // Hand-computed expectations.
  logic [2:0] fwd_lit [9] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0, 3'd1};
  logic [2:0] rev_lit [9] = '{3'd4, 3'd5, 3'd7, 3'd6, 3'd2, 3'd3, 3'd1, 3'd0, 3'd4};
  logic [2:0] rs6_lit [9] = '{3'd6, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0, 3'd1, 3'd3, 3'd2};

  initial begin
    int guard;
    total = 0;
    bad   = 0;
    for (int n = 0; n < 3; n++) begin
      idx[n] = 0; mval[n] = 1'b0; adv[n] = 1'b0; prev[n] = 3'd0;
    end
    rst_v = 3'b111;

    // t=20: reset edge at 10 has loaded every instance.
    @(negedge clk);
    chk("reset_fwd", q0, 3'd0);
    chk("reset_rev", q1, 3'd0);
    chk("reset_rs6", q2, 3'd6);
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;

    // t=40..200: forward, reverse, and RESET_STATE=6 held for three edges.
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk($sformatf("fwd_run%0d", k), q0, fwd_lit[k]);
      chk($sformatf("rev_run%0d", k), q1, rev_lit[k]);
      chk($sformatf("rs6_run%0d", k), q2, rs6_lit[k]);
      if (k == 1) rst_v[2] = 1'b0;
    end

    // Mid-sequence reset when the forward counter reaches 7.
    guard = 0;
    while (q0 !== 3'd7 && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    chk("reach7", q0, 3'd7);
    rst_v[0] = 1'b1;
    @(negedge clk);
    chk("midrst_load", q0, 3'd0);
    rst_v[0] = 1'b0;
    @(negedge clk);
    chk("midrst_succ", q0, 3'd1);

    // Two more full cycles under the per-cycle checks.
    repeat (16) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seq_counter
`default_nettype wire
